// File: rtl/mux_pkg.sv
// Shared constants and helpers for the round-robin / select-driven stream mux.
package mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Channel-index width: ceil(log2(n)), but never below one bit.
  function automatic int chan_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_stream_rr_arbiter.sv
// Round-robin arbiter: grants the first requester found after ptr, wrapping at N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N = 4,
  localparam int CW = chan_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [CW-1:0] gnt_idx
);

  // Scan from farthest to nearest so the channel right after ptr is written
  // last and therefore wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path through
    // this block leaves a signal unassigned, which would infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    for (int off = N; off >= 1; off--) begin
      if (req[(int'(ptr) + off) % N]) begin
        gnt                           = '0;
        gnt[(int'(ptr) + off) % N]    = 1'b1;
        gnt_idx                       = CW'((int'(ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/mux_rr_stream.sv
// N-to-1 stream mux with a single registered output stage; channel choice is
// either select-driven or round-robin.
module mux_rr_stream
  import mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = MODE_RR,
  localparam int CW   = chan_w(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  input  logic [CW-1:0]      sel,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [CW-1:0]      out_chan,
  input  logic               out_ready
);

  logic [N-1:0]     rr_gnt;
  logic [CW-1:0]    rr_idx;
  logic [N-1:0]     gnt;
  logic [CW-1:0]    gnt_idx;
  logic             accept;
  logic             load;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_data_d,  out_data_q;
  logic [CW-1:0]    out_chan_d,  out_chan_q;
  logic [CW-1:0]    ptr_d,       ptr_q;

  rr_arbiter #(.N(N)) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    if (MODE == MODE_SEL) begin
      // An out-of-range select simply grants nobody.
      if (int'(sel) < N && in_valid[sel]) begin
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end else begin
      gnt     = rr_gnt;
      gnt_idx = rr_idx;
    end
  end

  // The output slot is free when empty or when its word leaves this cycle.
  assign accept   = !out_valid_q || out_ready;
  assign load     = accept && (|gnt);
  assign in_ready = rst_n ? (gnt & {N{accept}}) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_chan_d  = gnt_idx;
      ptr_d       = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // ptr resets to N-1 so the first round-robin search starts at channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state flops use non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= CW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: a select-driven and a round-robin instance share
// stimulus and are compared every cycle against a queue-free reference model.
module tb_mux_rr_stream;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_valid = '0;
  logic [N*W-1:0] in_data = '0;
  logic [1:0]   sel = '0;
  logic         out_ready = 1'b0;

  logic [N-1:0] ir_sel, ir_rr;
  logic         ov_sel, ov_rr;
  logic [W-1:0] od_sel, od_rr;
  logic [1:0]   oc_sel, oc_rr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = select mode, 1 = round-robin mode.
  int m_valid[2];
  int m_data[2];
  int m_chan[2];
  int m_ptr[2];

  always #5 clk = ~clk;

  mux_rr_stream #(.WIDTH(W), .N(N), .MODE(0)) dut_sel (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir_sel), .sel(sel), .out_valid(ov_sel), .out_data(od_sel),
    .out_chan(oc_sel), .out_ready(out_ready)
  );

  mux_rr_stream #(.WIDTH(W), .N(N), .MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir_rr), .sel(sel), .out_valid(ov_rr), .out_data(od_rr),
    .out_chan(oc_rr), .out_ready(out_ready)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Which channel the rules say should win right now; -1 means none.
  function automatic int exp_grant(input int m);
    if (m == 0) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 1; k <= N; k++) begin
      if (in_valid[(m_ptr[1] + k) % N]) return (m_ptr[1] + k) % N;
    end
    return -1;
  endfunction

  function automatic int exp_ready(input int m);
    int g;
    g = exp_grant(m);
    if (!rst_n || g < 0) return 0;
    if (m_valid[m] != 0 && !out_ready) return 0;
    return 1 << g;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int m = 0; m < 2; m++) begin
      if (!rst_n) begin
        m_valid[m] = 0; m_data[m] = 0; m_chan[m] = 0; m_ptr[m] = N - 1;
      end else if (exp_ready(m) != 0) begin
        m_chan[m]  = exp_grant(m);
        m_data[m]  = int'(in_data[m_chan[m]*W +: W]);
        m_ptr[m]   = m_chan[m];
        m_valid[m] = 1;
      end else if (out_ready) begin
        m_valid[m] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("sel.out_valid", int'(ov_sel), m_valid[0]);
      check("sel.out_data",  int'(od_sel), m_data[0]);
      check("sel.out_chan",  int'(oc_sel), m_chan[0]);
      check("sel.in_ready",  int'(ir_sel), exp_ready(0));
      check("rr.out_valid",  int'(ov_rr),  m_valid[1]);
      check("rr.out_data",   int'(od_rr),  m_data[1]);
      check("rr.out_chan",   int'(oc_rr),  m_chan[1]);
      check("rr.in_ready",   int'(ir_rr),  exp_ready(1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #12;
    check("reset.rr.out_valid", int'(ov_rr), 0);
    check("reset.rr.in_ready", int'(ir_rr), 0);
    check("reset.sel.in_ready", int'(ir_sel), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // All channels valid: strict rotation 0,1,2,3,0.
    in_data = 32'h13121110; in_valid = 4'hF; out_ready = 1'b1; sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rot.chan", int'(oc_rr), i % 4);
      check("rot.data", int'(od_rr), 'h10 + i % 4);
    end

    // Backpressure holding 0x12 while inputs wander.
    reset_dut();
    repeat (3) tick();
    check("bp.data0", int'(od_rr), 'h12);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'($urandom); sel = 2'($urandom);
      #1 check("bp.in_ready", int'(ir_rr), 0);
      tick();
      check("bp.hold", int'(od_rr), 'h12);
      check("bp.valid", int'(ov_rr), 1);
    end
    in_valid = 4'hF; out_ready = 1'b1;
    #1 check("bp.release_ready", int'(ir_rr), 'b1000);
    tick();
    check("bp.next", int'(od_rr), 'h13);

    // Reset asserted mid-stall clears outputs without a clock edge.
    out_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst.valid", int'(ov_rr), 0);
    check("rst.data", int'(od_rr), 0);
    check("rst.chan", int'(oc_rr), 0);
    check("rst.in_ready", int'(ir_rr), 0);
    check("rst.sel_valid", int'(ov_sel), 0);
    out_ready = 1'b1;
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("rst.first_chan", int'(oc_rr), 0);
    check("rst.first_data", int'(od_rr), 'h10);

    // Only channels 1 and 3 requesting.
    reset_dut();
    in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #1 check("alt.ready_mask", int'(ir_rr & 4'b0101), 0);
      tick();
      check("alt.chan", int'(oc_rr), (i % 2 == 0) ? 1 : 3);
    end

    // Select-driven mode.
    reset_dut();
    sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00AB0000;
    tick();
    check("sel.data", int'(od_sel), 'hAB);
    check("sel.chan", int'(oc_sel), 2);
    sel = 2'd1;
    tick();
    check("sel.drain", int'(ov_sel), 0);
    check("sel.keep_data", int'(od_sel), 'hAB);

    // Idle gap keeps the rotation position.
    reset_dut();
    in_data = 32'h13121110; in_valid = 4'hF;
    tick();
    in_valid = 4'h0;
    tick();
    tick();
    check("idle.valid", int'(ov_rr), 0);
    check("idle.chan", int'(oc_rr), 0);
    in_valid = 4'hF;
    #1 check("idle.ready", int'(ir_rr), 'b0010);
    tick();
    check("idle.next", int'(oc_rr), 1);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) reset_dut();
      else tick();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_stream.md
MUX_RR_STREAM -- requirements
Module: mux_rr_stream

Interface
REQ-001 Parameter WIDTH, default 8: data width per channel, minimum 1.
REQ-002 Parameter N, default 4: number of input channels, minimum 2.
REQ-003 Parameter MODE, default 1: 0 = select-driven, 1 = round-robin.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, N: bit i set means channel i presents data.
REQ-007 Port in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port in_ready, output, N: bit i set means channel i transfers this cycle.
REQ-009 Port sel, input, CW = max(1,clog2(N)): channel index, used only in MODE 0.
REQ-010 Port out_valid, output, 1: output register holds a word.
REQ-011 Port out_data, output, WIDTH: registered word.
REQ-012 Port out_chan, output, CW: source channel of out_data.
REQ-013 Port out_ready, input, 1: downstream accepts the word this cycle.

Function
REQ-014 Input transfer on channel i SHALL occur when in_valid[i] & in_ready[i]; output transfer SHALL occur when out_valid & out_ready.
REQ-015 load = (!out_valid | out_ready) & (grant != 0); in_ready SHALL equal grant gated by (!out_valid | out_ready), with at most one bit set.
REQ-016 in_ready SHALL depend combinationally on in_valid, sel, out_valid, out_ready and the pointer only; out_valid, out_data and out_chan SHALL be registered.
REQ-017 MODE 0: grant SHALL be channel sel if in_valid[sel]; otherwise no grant; sel >= N SHALL produce no grant.
REQ-018 MODE 1: grant SHALL be the first valid channel searched from (ptr+1) mod N upward with wrap; ptr SHALL update to the granted index on each load only.
REQ-019 Latency SHALL be exactly 1 cycle: a word accepted at edge k is visible on out_data/out_chan after edge k.
REQ-020 Full throughput: with out_ready held high and a valid channel every cycle, one word per cycle SHALL transfer.
REQ-021 Backpressure: while out_valid & !out_ready, out_data, out_chan and out_valid SHALL hold, in_ready SHALL be all zero, and ptr SHALL hold.
REQ-022 On an output transfer with no grant, out_valid SHALL clear on the next edge; out_data and out_chan keep their last value.
REQ-023 Simultaneous output transfer and load SHALL replace the word in the same edge with no bubble.
REQ-024 Changing sel or in_valid while stalled SHALL NOT alter held output.
REQ-025 MODE 1 fairness: with all N channels continuously valid and out_ready high, grants SHALL cycle 0,1,...,N-1,0 with no repeats.

Reset
REQ-026 Assertion of rst_n low SHALL immediately clear out_valid, out_data and out_chan to zero and set ptr to N-1, independent of clk.
REQ-027 in_ready SHALL be all zero while rst_n is low.
REQ-028 Reset mid-stall SHALL discard the held word; no transfer SHALL occur on the first edge after deassertion unless a channel is valid, in which case normal arbitration resumes with channel 0 first.

Structure
REQ-029 Package mux_pkg SHALL hold MODE_SEL=0 and MODE_RR=1 constants and the channel-index width function.
REQ-030 Round-robin grant logic SHALL be a sub-module rr_arbiter (N, request vector, pointer in, one-hot grant and index out); the top owns the output register and ptr.

Verification
REQ-031 Reset: rst_n low mid-stall with out_valid=1 -> out_valid=0, out_data=0, in_ready=0 immediately, before any clk edge.
REQ-032 MODE 1, N=4, WIDTH=8, all valid, data 0x10+i, out_ready=1 -> out_chan 0,1,2,3,0, out_data 0x10,0x11,0x12,0x13,0x10 on consecutive cycles.
REQ-033 MODE 1, only channels 1 and 3 valid -> out_chan alternates 1,3,1,3; in_ready[0] and in_ready[2] are never set.
REQ-034 Backpressure: out_ready=0 for 3 cycles with out_data=0x12 -> out_data holds 0x12, in_ready=0; on out_ready=1 the next word loads in the same edge.
REQ-035 MODE 0, sel=2, in_valid=4'b0100, data 0xAB -> out_data=0xAB, out_chan=2 after one edge; sel=1 with in_valid[1]=0 -> no grant, out_valid clears after consumption.
REQ-036 Idle: in_valid=0 for 2 cycles after a transfer -> out_valid=0 and ptr unchanged; the next grant continues the rotation.
